la_capture_ctrl: RTL and testbench

Capture sequencer for the logic-analyzer path. It owns the circular sample-memory write pointer and fills a programmable pre-trigger window. It then arms the LA trigger block via its enable and waits for the trigger. After the trigger it writes a programmable number of post-trigger samples, reports the trigger address and flags completion to the host interface.

---
 rtl/la_capture_ctrl.sv | 150 +++++++++++++++
 tb/tb_la_capture_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: logic-analyzer capture sequencer (pre-trigger fill, arm, post-trigger fill).
// Define LA_AUTO_TRIG_EN to build the auto-trigger timeout; without it ARMED waits indefinitely.
module la_capture_ctrl #(
  parameter int ADDR_W = 13,
  parameter int BLANK  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              SMPL_CE,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  input  logic [15:0]       AUTO_TMO,
  input  logic              TRIG_IN,
  output logic              TRIG_EN,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              AUTO_FLAG
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  // The blanking window covers the cycle in which the trigger block registers
  // TRIG_EN plus its BLANK-deep pipeline, so it is BLANK+1 ARMED cycles long.
  localparam int                 BLANK_W    = $clog2(BLANK + 2);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK + 1);

  state_t             state;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  trig_addr;
  logic [ADDR_W-1:0]  cnt;
  logic [BLANK_W-1:0] blank_cnt;
  logic               trig_pend;
  logic               capture;
  logic               start_ok;
  logic               armed_live;
  logic               real_trig;
  logic               auto_trig;
  logic               fire;

  assign capture    = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign start_ok   = START && ((state == S_IDLE) || (state == S_DONE));
  assign armed_live = (state == S_ARMED) && (blank_cnt == '0);
  assign real_trig  = armed_live && (TRIG_IN || trig_pend);
  assign fire       = WR_EN && (real_trig || auto_trig);

  assign WR_EN     = capture && SMPL_CE;
  assign BUSY      = capture;
  assign TRIG_EN   = (state == S_ARMED);
  assign DONE      = (state == S_DONE);
  assign WR_ADDR   = wr_addr;
  assign TRIG_ADDR = trig_addr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; later assignments in the block deliberately override earlier ones.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      wr_addr   <= '0;
      trig_addr <= '0;
      cnt       <= '0;
      blank_cnt <= '0;
      trig_pend <= 1'b0;
    end else if (ABORT) begin
      state     <= S_IDLE;
      wr_addr   <= '0;
      trig_pend <= 1'b0;
    end else begin
      if (WR_EN) wr_addr <= wr_addr + ADDR_W'(1);

      unique case (state)
        S_IDLE: wr_addr <= '0;
        S_PRE: begin
          if (WR_EN) begin
            cnt <= cnt - ADDR_W'(1);
            if (cnt == ADDR_W'(1)) begin
              state     <= S_ARMED;
              blank_cnt <= BLANK_LOAD;
            end
          end
        end
        S_ARMED: begin
          if (blank_cnt != '0) blank_cnt <= blank_cnt - BLANK_W'(1);
          if (fire) begin
            trig_addr <= wr_addr;
            cnt       <= POST_CNT;
            trig_pend <= 1'b0;
            state     <= (POST_CNT == '0) ? S_DONE : S_POST;
          end else if (armed_live && TRIG_IN) begin
            // Trigger seen between sample strobes: hold it for the next write.
            trig_pend <= 1'b1;
          end
        end
        S_POST: begin
          if (WR_EN) begin
            cnt <= cnt - ADDR_W'(1);
            if (cnt == ADDR_W'(1)) state <= S_DONE;
          end
        end
        default: ;
      endcase

      if (start_ok) begin
        wr_addr   <= '0;
        cnt       <= PRE_CNT;
        blank_cnt <= BLANK_LOAD;
        trig_pend <= 1'b0;
        state     <= (PRE_CNT == '0) ? S_ARMED : S_PRE;
      end
    end
  end

`ifdef LA_AUTO_TRIG_EN
  logic [15:0] tmo_cnt;
  logic        auto_pend;
  logic        auto_flag;

  assign auto_trig = armed_live && auto_pend;
  assign AUTO_FLAG = auto_flag;

  always_ff @(posedge CLK) begin
    if (!RST || ABORT) begin
      tmo_cnt   <= '0;
      auto_pend <= 1'b0;
      auto_flag <= 1'b0;
    end else begin
      if (start_ok) auto_flag <= 1'b0;
      // A real trigger coinciding with the timeout takes precedence.
      if (fire) auto_flag <= !real_trig;
      if (state != S_ARMED) begin
        tmo_cnt   <= '0;
        auto_pend <= 1'b0;
      end else if (armed_live && !auto_pend) begin
        tmo_cnt <= tmo_cnt + 16'd1;
        if ((AUTO_TMO != 16'd0) && (tmo_cnt + 16'd1 == AUTO_TMO)) auto_pend <= 1'b1;
      end
    end
  end
`else
  logic unused_auto_tmo;
  assign unused_auto_tmo = ^AUTO_TMO;
  assign auto_trig       = 1'b0;
  assign AUTO_FLAG       = 1'b0;
`endif

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed testbench for la_capture_ctrl with ADDR_W = 4, BLANK = 3.
module tb_la_capture_ctrl;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic          SMPL_CE = 1'b0;
  logic          TRIG_IN = 1'b0;
  logic [AW-1:0] PRE_CNT = '0;
  logic [AW-1:0] POST_CNT = '0;
  logic [15:0]   AUTO_TMO = '0;
  logic          TRIG_EN, WR_EN, BUSY, DONE, AUTO_FLAG;
  logic [AW-1:0] WR_ADDR, TRIG_ADDR;

  int errors = 0;
  int checks = 0;

  la_capture_ctrl #(.ADDR_W(AW), .BLANK(3)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .SMPL_CE(SMPL_CE),
    .PRE_CNT(PRE_CNT), .POST_CNT(POST_CNT), .AUTO_TMO(AUTO_TMO), .TRIG_IN(TRIG_IN),
    .TRIG_EN(TRIG_EN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .TRIG_ADDR(TRIG_ADDR),
    .BUSY(BUSY), .DONE(DONE), .AUTO_FLAG(AUTO_FLAG)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Flags are compared as {TRIG_EN, WR_EN, BUSY, DONE}.
  task automatic test_reset();
    RST = 1'b0;
    SMPL_CE = 1'b1;
    step();
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, AUTO_FLAG} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", {TRIG_EN, WR_EN, BUSY, DONE, AUTO_FLAG}, 5'b00000);
    end
    checks++;
    if ({WR_ADDR, TRIG_ADDR} !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr: got %h expected %h", {WR_ADDR, TRIG_ADDR}, 8'h00);
    end
    RST = 1'b1;
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", {TRIG_EN, WR_EN, BUSY, DONE}, 4'b0000);
    end
  endtask

  task automatic test_basic();
    SMPL_CE = 1'b1;
    PRE_CNT = 4'd3;
    POST_CNT = 4'd2;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0110, 4'(i)}) begin
        errors++;
        $display("FAIL basic_pre i=%0d: got %b/%0d expected %b/%0d", i, {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR, 4'b0110, i);
      end
      step();
    end
    for (int c = 1; c <= 6; c++) begin
      TRIG_IN = (c == 4) || (c == 6);
      #1;
      checks++;
      if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b1110, 4'(c + 2)}) begin
        errors++;
        $display("FAIL basic_armed c=%0d: got %b/%0d expected %b/%0d", c, {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR, 4'b1110, c + 2);
      end
      step();
    end
    TRIG_IN = 1'b0;
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, TRIG_ADDR, WR_ADDR} !== {4'b0110, 4'd8, 4'd9}) begin
      errors++;
      $display("FAIL basic_post1: got %b/%0d/%0d expected 0110/8/9", {TRIG_EN, WR_EN, BUSY, DONE}, TRIG_ADDR, WR_ADDR);
    end
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0110, 4'd10}) begin
      errors++;
      $display("FAIL basic_post2: got %b/%0d expected 0110/10", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0001, 4'd11}) begin
      errors++;
      $display("FAIL basic_done: got %b/%0d expected 0001/11", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0001, 4'd11}) begin
      errors++;
      $display("FAIL basic_done_hold: got %b/%0d expected 0001/11", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
  endtask

  task automatic test_zero_counts();
    PRE_CNT = 4'd0;
    POST_CNT = 4'd0;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      TRIG_IN = (c == 5);
      #1;
      checks++;
      if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b1110, 4'(c - 1)}) begin
        errors++;
        $display("FAIL zero_armed c=%0d: got %b/%0d expected %b/%0d", c, {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR, 4'b1110, c - 1);
      end
      step();
    end
    TRIG_IN = 1'b0;
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, TRIG_ADDR, WR_ADDR} !== {4'b0001, 4'd4, 4'd5}) begin
      errors++;
      $display("FAIL zero_done: got %b/%0d/%0d expected 0001/4/5", {TRIG_EN, WR_EN, BUSY, DONE}, TRIG_ADDR, WR_ADDR);
    end
  endtask

  task automatic test_ce_wrap();
    logic [AW-1:0] exp_addr;
    logic          exp_we, exp_te;
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0000, 4'd0}) begin
      errors++;
      $display("FAIL abort_from_done: got %b/%0d expected 0000/0", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
    PRE_CNT = 4'd15;
    POST_CNT = 4'd1;
    SMPL_CE = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    exp_addr = '0;
    for (int k = 1; k <= 69; k++) begin
      exp_we = (k % 4 == 1);
      exp_te = (k >= 58) && (k <= 65);
      SMPL_CE = exp_we;
      TRIG_IN = (k == 63);
      #1;
      checks++;
      if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {exp_te, exp_we, 2'b10, exp_addr}) begin
        errors++;
        $display("FAIL ce_wrap k=%0d: got %b/%0d expected %b/%0d", k, {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR, {exp_te, exp_we, 2'b10}, exp_addr);
      end
      if (exp_we) exp_addr = exp_addr + 4'd1;
      step();
    end
    SMPL_CE = 1'b0;
    TRIG_IN = 1'b0;
    #1;
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, TRIG_ADDR, WR_ADDR} !== {4'b0001, 4'd0, 4'd2}) begin
      errors++;
      $display("FAIL ce_wrap_done: got %b/%0d/%0d expected 0001/0/2", {TRIG_EN, WR_EN, BUSY, DONE}, TRIG_ADDR, WR_ADDR);
    end
  endtask

  task automatic test_abort_start_post();
    SMPL_CE = 1'b1;
    PRE_CNT = 4'd2;
    POST_CNT = 4'd5;
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    // START mid-capture with a new PRE_CNT must be ignored.
    START = 1'b1;
    PRE_CNT = 4'd9;
    step();
    START = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      TRIG_IN = (c == 5);
      #1;
      checks++;
      if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b1110, 4'(c + 1)}) begin
        errors++;
        $display("FAIL ignore_start c=%0d: got %b/%0d expected %b/%0d", c, {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR, 4'b1110, c + 1);
      end
      step();
    end
    TRIG_IN = 1'b0;
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, TRIG_ADDR, WR_ADDR} !== {4'b0110, 4'd6, 4'd7}) begin
      errors++;
      $display("FAIL post_entry: got %b/%0d/%0d expected 0110/6/7", {TRIG_EN, WR_EN, BUSY, DONE}, TRIG_ADDR, WR_ADDR);
    end
    ABORT = 1'b1;
    START = 1'b1;
    step();
    ABORT = 1'b0;
    START = 1'b0;
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0000, 4'd0}) begin
      errors++;
      $display("FAIL abort_wins: got %b/%0d expected 0000/0", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle_hold: got %b expected 0000", {TRIG_EN, WR_EN, BUSY, DONE});
    end
    PRE_CNT = 4'd2;
    START = 1'b1;
    step();
    START = 1'b0;
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0110, 4'd0}) begin
      errors++;
      $display("FAIL restart: got %b/%0d expected 0110/0", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
  endtask

  task automatic test_reset_armed();
    step();
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b1110, 4'd2}) begin
      errors++;
      $display("FAIL rst_pre_armed: got %b/%0d expected 1110/2", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
    step();
    RST = 1'b0;
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, AUTO_FLAG, WR_ADDR, TRIG_ADDR} !== {5'b00000, 8'h00}) begin
      errors++;
      $display("FAIL rst_armed: got %b/%0d/%0d expected 00000/0/0", {TRIG_EN, WR_EN, BUSY, DONE, AUTO_FLAG}, WR_ADDR, TRIG_ADDR);
    end
    RST = 1'b1;
    step();
    checks++;
    if ({TRIG_EN, WR_EN, BUSY, DONE, WR_ADDR} !== {4'b0000, 4'd0}) begin
      errors++;
      $display("FAIL rst_release: got %b/%0d expected 0000/0", {TRIG_EN, WR_EN, BUSY, DONE}, WR_ADDR);
    end
  endtask

  task automatic test_auto();
    int bad;
    PRE_CNT = 4'd0;
    POST_CNT = 4'd0;
    AUTO_TMO = 16'd10;
    TRIG_IN = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
`ifdef LA_AUTO_TRIG_EN
    for (int c = 1; c <= 15; c++) step();
    checks++;
    if ({DONE, AUTO_FLAG, TRIG_ADDR} !== {2'b11, 4'd14}) begin
      errors++;
      $display("FAIL auto_forced: got %b/%0d expected 11/14", {DONE, AUTO_FLAG}, TRIG_ADDR);
    end
`else
    bad = 0;
    for (int c = 1; c <= 1000; c++) begin
      if ({TRIG_EN, BUSY, DONE, AUTO_FLAG} !== 4'b1100) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL armed_hold: got %0d bad cycles expected 0", bad);
    end
`endif
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    checks++;
    if ({TRIG_EN, BUSY, DONE, AUTO_FLAG} !== 4'b0000) begin
      errors++;
      $display("FAIL auto_abort: got %b expected 0000", {TRIG_EN, BUSY, DONE, AUTO_FLAG});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_counts();
    test_ce_wrap();
    test_abort_start_post();
    test_reset_armed();
    test_auto();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
